// File: rtl/phoenix_memory_model.sv
// phoeniX memory model: dual-port word memory with per-port wait states, console FIFO and halt MMIO.
// Optional activity counters are enabled by defining PHOENIX_MEMORY_MODEL_ACTIVITY_COUNTERS_EN.

module phoenix_mem_port_fsm #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic hold,
  output logic accept,
  output logic resp
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (enable) begin
          cnt   <= 4'(LATENCY - 1);
          state <= (LATENCY == 1) ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: if (!hold) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign accept = (state == IDLE) && enable;
  assign resp   = (state == RESP);
endmodule

module phoenix_memory_model #(
  parameter int          DEPTH_WORDS   = 8388608,
  parameter int          IMEM_LATENCY  = 1,
  parameter int          DMEM_LATENCY  = 1,
  parameter logic [31:0] CONSOLE_ADDR  = 32'h1000_0000,
  parameter logic [31:0] HALT_ADDR     = 32'h1000_0004,
  parameter int          CONSOLE_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_enable,
  input  logic [31:0] imem_address,
  output logic [31:0] imem_data,
  output logic        imem_ready,
  output logic        imem_error,
  input  logic        dmem_enable,
  input  logic        dmem_state,
  input  logic [31:0] dmem_address,
  input  logic [3:0]  dmem_frame_mask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_error,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready,
  output logic        halted,
  output logic [31:0] exit_code,
  output logic [31:0] imem_active_cycles,
  output logic [31:0] imem_idle_cycles
);
  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam int          PW      = $clog2(CONSOLE_DEPTH);
  localparam logic [31:0] DEPTH_U = DEPTH_WORDS;

  logic [31:0] mem [DEPTH_WORDS];
  logic [7:0]  fifo [CONSOLE_DEPTH];

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{imem_address[1:0], dmem_address[1:0]};

  logic i_accept, i_resp, d_accept, d_resp, d_hold;

  phoenix_mem_port_fsm #(.LATENCY(IMEM_LATENCY)) u_ifsm (
    .clk(clk), .reset(reset), .enable(imem_enable), .hold(1'b0),
    .accept(i_accept), .resp(i_resp));

  phoenix_mem_port_fsm #(.LATENCY(DMEM_LATENCY)) u_dfsm (
    .clk(clk), .reset(reset), .enable(dmem_enable), .hold(d_hold),
    .accept(d_accept), .resp(d_resp));

  // Request fields are captured only at acceptance; later input changes are ignored.
  logic [29:0] i_word, d_word;
  logic        d_wr;
  logic [3:0]  d_mask;
  logic [31:0] d_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_word  <= '0;
      d_word  <= '0;
      d_wr    <= 1'b0;
      d_mask  <= '0;
      d_wdata <= '0;
    end else begin
      if (i_accept) i_word <= imem_address[31:2];
      if (d_accept) begin
        d_word  <= dmem_address[31:2];
        d_wr    <= dmem_state;
        d_mask  <= dmem_frame_mask;
        d_wdata <= dmem_wdata;
      end
    end
  end

  logic i_con, i_halt, i_oob, d_con, d_halt, d_oob;
  assign i_con  = (i_word == CONSOLE_ADDR[31:2]);
  assign i_halt = (i_word == HALT_ADDR[31:2]);
  assign i_oob  = !i_con && !i_halt && ({2'b00, i_word} >= DEPTH_U);
  assign d_con  = (d_word == CONSOLE_ADDR[31:2]);
  assign d_halt = (d_word == HALT_ADDR[31:2]);
  assign d_oob  = !d_con && !d_halt && ({2'b00, d_word} >= DEPTH_U);

  // Console FIFO: pointers carry a wrap bit so full and empty are distinguishable.
  logic [PW:0] wr_ptr, rd_ptr;
  logic        fifo_full, fifo_empty, push, pop;
  assign fifo_full  = (wr_ptr == {~rd_ptr[PW], rd_ptr[PW-1:0]});
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign pop        = console_ready && !fifo_empty;

  // A console write stalls in RESP on a full FIFO unless a pop frees a slot this cycle.
  assign d_hold     = d_wr && d_con && fifo_full && !pop;
  assign dmem_ready = d_resp && !d_hold;
  assign push       = dmem_ready && d_wr && d_con;

  assign imem_ready    = i_resp;
  assign imem_error    = i_resp && i_oob;
  assign dmem_error    = dmem_ready && d_oob;
  assign console_valid = !fifo_empty;
  assign console_data  = fifo_empty ? 8'h00 : fifo[rd_ptr[PW-1:0]];

  // Reads are combinational in RESP, so a same-cycle data write is not yet visible.
  always_comb begin
    imem_data = '0;
    if (i_resp && !i_oob)
      imem_data = i_con ? {31'b0, fifo_full} : i_halt ? exit_code : mem[i_word[AW-1:0]];
  end

  always_comb begin
    dmem_rdata = '0;
    if (dmem_ready && !d_oob)
      dmem_rdata = d_con ? {31'b0, fifo_full} : d_halt ? exit_code : mem[d_word[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      halted    <= 1'b0;
      exit_code <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (dmem_ready && d_wr && d_halt) begin
        halted    <= 1'b1;
        exit_code <= d_wdata;
      end
    end
  end

  // Storage is not reset so memory contents survive reset.
  logic mem_we;
  assign mem_we = dmem_ready && d_wr && !d_oob && !d_con && !d_halt;

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[PW-1:0]] <= d_wdata[7:0];
    for (int b = 0; b < 4; b++)
      if (mem_we && d_mask[3-b]) mem[d_word[AW-1:0]][8*b +: 8] <= d_wdata[8*b +: 8];
  end

`ifdef PHOENIX_MEMORY_MODEL_ACTIVITY_COUNTERS_EN
  logic [31:0] act_q, idle_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q  <= '0;
      idle_q <= '0;
    end else begin
      if (imem_enable && act_q != 32'hFFFF_FFFF)   act_q  <= act_q + 32'd1;
      if (!imem_enable && idle_q != 32'hFFFF_FFFF) idle_q <= idle_q + 32'd1;
    end
  end
  assign imem_active_cycles = act_q;
  assign imem_idle_cycles   = idle_q;
`else
  assign imem_active_cycles = '0;
  assign imem_idle_cycles   = '0;
`endif
endmodule

// File: tb/tb_phoenix_memory_model.sv
// Directed bench for phoenix_memory_model: latency, masking, collision, range, console, halt, reset.
module tb_phoenix_memory_model;
  logic        clk, reset;
  logic        imem_enable, imem_ready, imem_error;
  logic [31:0] imem_address, imem_data;
  logic        dmem_enable, dmem_state, dmem_ready, dmem_error;
  logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_frame_mask;
  logic        console_valid, console_ready, halted;
  logic [7:0]  console_data;
  logic [31:0] exit_code, imem_active_cycles, imem_idle_cycles;

  int total = 0;
  int bad   = 0;

  phoenix_memory_model #(
    .DEPTH_WORDS(64), .IMEM_LATENCY(3), .DMEM_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_enable(imem_enable), .imem_address(imem_address), .imem_data(imem_data),
    .imem_ready(imem_ready), .imem_error(imem_error),
    .dmem_enable(dmem_enable), .dmem_state(dmem_state), .dmem_address(dmem_address),
    .dmem_frame_mask(dmem_frame_mask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .dmem_error(dmem_error),
    .console_valid(console_valid), .console_data(console_data), .console_ready(console_ready),
    .halted(halted), .exit_code(exit_code),
    .imem_active_cycles(imem_active_cycles), .imem_idle_cycles(imem_idle_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dacc(input logic wr, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] wd, output logic [31:0] rd, output logic err,
                      output int lat);
    dmem_enable = 1'b1; dmem_state = wr; dmem_address = addr;
    dmem_frame_mask = mask; dmem_wdata = wd;
    tick();
    dmem_enable = 1'b0; dmem_address = 32'hFFFF_FFF0; dmem_wdata = '0; dmem_frame_mask = '0;
    lat = 1;
    while (!dmem_ready && lat < 40) begin tick(); lat++; end
    chk("dmem_timeout", lat < 40, 1'b1);
    rd = dmem_rdata; err = dmem_error;
    tick();
  endtask

  task automatic iacc(input logic [31:0] addr, output logic [31:0] rd, output logic err,
                      output int lat);
    imem_enable = 1'b1; imem_address = addr;
    tick();
    imem_enable = 1'b0; imem_address = 32'hFFFF_FFF0;
    lat = 1;
    while (!imem_ready && lat < 40) begin tick(); lat++; end
    chk("imem_timeout", lat < 40, 1'b1);
    rd = imem_data; err = imem_error;
    tick();
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat, n;
  logic [7:0]  last;

  initial begin
    reset = 1'b1; imem_enable = 0; imem_address = 0; dmem_enable = 0; dmem_state = 0;
    dmem_address = 0; dmem_frame_mask = 0; dmem_wdata = 0; console_ready = 0;
    tick(); tick();
    chk("rst_flags", {imem_ready, imem_error, dmem_ready, dmem_error, console_valid, halted}, 0);
    chk("rst_idata", imem_data, 0);
    chk("rst_ddata", dmem_rdata, 0);
    chk("rst_exit", exit_code, 0);
    chk("rst_cdata", console_data, 0);
    reset = 1'b0;
    tick();

    // Preload and instruction fetch latency
    dacc(1, 32'h10, 4'hF, 32'h0051_0113, rd, err, lat);
    chk("dwr_lat", lat, 2);
    chk("dwr_err", err, 0);
    iacc(32'h10, rd, err, lat);
    chk("ifetch_lat", lat, 3);
    chk("ifetch_data", rd, 32'h0051_0113);
    chk("ifetch_err", err, 0);

    // Byte masks
    dacc(1, 32'h20, 4'hF, 32'h1122_3344, rd, err, lat);
    dacc(1, 32'h20, 4'b1000, 32'hAABB_CCDD, rd, err, lat);
    dacc(0, 32'h20, 4'h0, 0, rd, err, lat);
    chk("mask_1000", rd, 32'h1122_33DD);
    dacc(0, 32'h23, 4'h0, 0, rd, err, lat);
    chk("addr_lsb_ignored", rd, 32'h1122_33DD);
    dacc(1, 32'h20, 4'b0110, 32'hAABB_CCDD, rd, err, lat);
    dacc(0, 32'h20, 4'h0, 0, rd, err, lat);
    chk("mask_0110", rd, 32'h11BB_CCDD);

    // Same-cycle instruction read and data write to one word
    imem_enable = 1; imem_address = 32'h20;
    tick();
    imem_enable = 0; dmem_enable = 1; dmem_state = 1; dmem_address = 32'h20;
    dmem_frame_mask = 4'hF; dmem_wdata = 32'hCAFE_F00D;
    tick();
    dmem_enable = 0;
    tick();
    chk("coll_ready", {imem_ready, dmem_ready}, 2'b11);
    chk("coll_idata", imem_data, 32'h11BB_CCDD);
    tick();
    dacc(0, 32'h20, 4'h0, 0, rd, err, lat);
    chk("coll_after", rd, 32'hCAFE_F00D);

    // Out of range
    dacc(0, 32'h100, 4'h0, 0, rd, err, lat);
    chk("oob_rd_err", err, 1);
    chk("oob_rd_data", rd, 0);
    dacc(1, 32'h110, 4'hF, 32'hDEAD_BEEF, rd, err, lat);
    chk("oob_wr_err", err, 1);
    iacc(32'h10, rd, err, lat);
    chk("oob_no_alias", rd, 32'h0051_0113);
    iacc(32'h100, rd, err, lat);
    chk("oob_ifetch", {err, rd}, {1'b1, 32'h0});

    // Console FIFO
    dacc(1, 32'h1000_0000, 4'hF, 32'h48, rd, err, lat);
    dacc(1, 32'h1000_0000, 4'hF, 32'h69, rd, err, lat);
    chk("con_valid", console_valid, 1);
    chk("con_head0", console_data, 8'h48);
    console_ready = 1; tick(); console_ready = 0;
    chk("con_head1", console_data, 8'h69);
    for (int k = 0; k < 15; k++) dacc(1, 32'h1000_0000, 4'hF, 32'h30 + k, rd, err, lat);
    dacc(0, 32'h1000_0000, 4'h0, 0, rd, err, lat);
    chk("con_full_rd", rd, 1);
    dmem_enable = 1; dmem_state = 1; dmem_address = 32'h1000_0000; dmem_wdata = 32'hEE;
    dmem_frame_mask = 4'hF;
    tick();
    dmem_enable = 0;
    repeat (5) tick();
    chk("con_stall", dmem_ready, 0);
    console_ready = 1; #1;
    chk("con_pushpop", dmem_ready, 1);
    tick(); console_ready = 0;
    chk("con_head2", console_data, 8'h30);
    n = 0; last = 0; console_ready = 1;
    while (console_valid && n < 40) begin last = console_data; n++; tick(); end
    console_ready = 0;
    chk("con_drain_n", n, 16);
    chk("con_drain_last", last, 8'hEE);

    // Halt register
    dacc(1, 32'h1000_0004, 4'hF, 32'h0000_002A, rd, err, lat);
    chk("halt_flag", halted, 1);
    chk("halt_code", exit_code, 42);
    dacc(0, 32'h1000_0004, 4'h0, 0, rd, err, lat);
    chk("halt_rd", {err, rd}, {1'b0, 32'd42});
    dacc(1, 32'h1000_0004, 4'hF, 32'h7, rd, err, lat);
    chk("halt_sticky", {halted, exit_code}, {1'b1, 32'h7});

    // Reset while an instruction request waits
    imem_enable = 1; imem_address = 32'h20;
    tick();
    imem_enable = 0; reset = 1; #1;
    chk("rst2_flags", {imem_ready, imem_error, dmem_ready, dmem_error, console_valid, halted}, 0);
    chk("rst2_exit", exit_code, 0);
    chk("rst2_idata", imem_data, 0);
    tick(); reset = 0;

    for (int i = 0; i < 25; i++) begin
      imem_enable = (i < 10); imem_address = 32'h10;
      tick();
    end
    imem_enable = 0;
`ifdef PHOENIX_MEMORY_MODEL_ACTIVITY_COUNTERS_EN
    chk("cnt_active", imem_active_cycles, 10);
    chk("cnt_idle", imem_idle_cycles, 15);
`else
    chk("cnt_active", imem_active_cycles, 0);
    chk("cnt_idle", imem_idle_cycles, 0);
`endif
    repeat (5) tick();
    dacc(0, 32'h20, 4'h0, 0, rd, err, lat);
    chk("retain_d", rd, 32'hCAFE_F00D);
    iacc(32'h10, rd, err, lat);
    chk("retain_i", rd, 32'h0051_0113);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/phoenix_memory_model.md
Name: phoenix_memory_model

Overview:
- Parametrised, cycle-accurate memory subsystem model for phoeniX simulation and FPGA bring-up.
- Replaces the fixed zero-wait-state negedge memory with a dual-port word memory:
  - an instruction port (read-only) and a data port (read/write, byte-masked);
  - per-port programmable wait states with a ready handshake;
  - a buffered console MMIO channel and a halt/exit-code MMIO register.
- Sits between the phoeniX memory interfaces and the top-level bench or FPGA wrapper.

Parameters:
- DEPTH_WORDS, 8388608, number of 32-bit words; word index = address >> 2.
- IMEM_LATENCY, 1, cycles from instruction request acceptance to imem_ready; legal range 1..15.
- DMEM_LATENCY, 1, cycles from data request acceptance to dmem_ready; legal range 1..15.
- CONSOLE_ADDR, 32'h1000_0000, byte address of the console write register.
- HALT_ADDR, 32'h1000_0004, byte address of the halt/exit-code register.
- CONSOLE_DEPTH, 16, console FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- imem_enable  input  1  instruction request valid
- imem_address  input  32  instruction byte address
- imem_data  output  32  instruction read data
- imem_ready  output  1  one-cycle response strobe
- imem_error  output  1  out-of-range flag, valid with imem_ready
- dmem_enable  input  1  data request valid
- dmem_state  input  1  0 = READ, 1 = WRITE
- dmem_address  input  32  data byte address
- dmem_frame_mask  input  4  byte enables: bit3 = [7:0], bit2 = [15:8], bit1 = [23:16], bit0 = [31:24]
- dmem_wdata  input  32  write data
- dmem_rdata  output  32  read data
- dmem_ready  output  1  one-cycle response strobe
- dmem_error  output  1  out-of-range flag, valid with dmem_ready
- console_valid  output  1  console FIFO non-empty
- console_data  output  8  FIFO head byte
- console_ready  input  1  consumer pops the FIFO head when high with console_valid
- halted  output  1  sticky halt flag
- exit_code  output  32  value written to HALT_ADDR
- imem_active_cycles  output  32  see Optional Feature
- imem_idle_cycles  output  32  see Optional Feature

Behaviour:
- Reset: asynchronous and active-high; the clock is the single clk.
  - While reset is high: every output is 0, both port FSMs are in IDLE, the console FIFO is emptied, halted and exit_code are cleared.
  - Memory contents are preserved across reset.
- Each port runs an independent FSM: IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: enable=1 accepts the request. Address, state, mask and wdata are latched, the latency counter loads LATENCY-1, and the FSM moves to WAIT. If LATENCY=1 it moves straight to RESP.
  - WAIT: the counter decrements; the FSM moves to RESP when the count reaches 0.
  - RESP: ready=1 for exactly one cycle; read data is valid in the same cycle; the FSM returns to IDLE.
  - A new request may be accepted in the cycle after RESP. Back-to-back throughput is one request per LATENCY+1 cycles.
- Request inputs are sampled only at acceptance. Changes during WAIT are ignored. Dropping enable during WAIT does not cancel the transaction.
- Address bits [1:0] are ignored (word access).
- Address range:
  - Word index >= DEPTH_WORDS and not an MMIO address: error=1 with ready, read data 0, write discarded.
  - MMIO addresses never flag an error.
- Reads:
  - Full 32-bit word, mask ignored.
  - Reading CONSOLE_ADDR returns {31'b0, FIFO full}.
  - Reading HALT_ADDR returns exit_code.
- Data writes commit in the RESP cycle, only the masked bytes.
  - Instruction/data collision: an instruction RESP and a data-write RESP to the same word in the same cycle returns pre-write data to the instruction port.
- Console write:
  - In RESP, byte [7:0] of the latched wdata is pushed to the FIFO.
  - If the FIFO is full, the data FSM holds in RESP with dmem_ready=0 until space frees.
  - A simultaneous pop and push on a full FIFO succeeds in that same cycle.
- Halt write: sets halted=1 and exit_code=wdata.
  - halted is sticky until reset; later HALT writes update exit_code only.
  - The model keeps servicing both ports after halt.
- FIFO pointers carry one extra wrap bit; full = pointers equal except MSB, empty = pointers fully equal.

Optional Feature:
- Macro: PHOENIX_MEMORY_MODEL_ACTIVITY_COUNTERS_EN.
- Defined:
  - imem_active_cycles increments every cycle with imem_enable=1 and reset low.
  - imem_idle_cycles increments every other cycle with reset low.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Not defined: both outputs are tied to 0 and no counter flops are generated.

Test Plan:
- IMEM_LATENCY=3, word 4 = 32'h0051_0113, imem request to 0x10 -> imem_ready high exactly 3 cycles after acceptance, imem_data=32'h0051_0113, imem_error=0.
- Data write to 0x20 with mask 4'b1000, wdata 32'hAABB_CCDD, over word 32'h1122_3344 -> readback 32'h1122_33DD.
- Console:
  - write 'H', 'i' to 0x1000_0000 with console_ready=0 -> console_valid=1, console_data=8'h48;
  - pulse console_ready -> console_data=8'h69;
  - fill 16 entries, then write again -> dmem_ready withheld until one pop.
- Read of word DEPTH_WORDS*4 -> dmem_error=1, dmem_rdata=0; memory unchanged.
- Write 32'h0000_002A to 0x1000_0004 -> halted=1, exit_code=42; assert reset mid-WAIT -> all outputs 0 immediately, memory retained.
- With the macro defined, hold imem_enable 10 of 25 cycles -> imem_active_cycles=10, imem_idle_cycles=15.
